// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a retired-instruction counter.
// Define MC_ILLEGAL_TRAP_EN to send illegal opcodes to a halting TRAP state instead of retiring them as NOPs.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             r_type,
    output logic             i_type,
    output logic             alu_add,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             halt,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL
    } cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, dec_cls;
    logic [CNT_W-1:0] count_q;
    logic             retire;

    function automatic cls_t decode(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            default:    return C_ILLEGAL;
        endcase
    endfunction

    assign dec_cls = decode(opcode);

    // State, class and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_ILLEGAL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    // Next state and decoded control outputs; reset forces every output low.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        r_type  = 1'b0;
        i_type  = 1'b0;
        alu_add = 1'b0;
        reg_we  = 1'b0;
        wb_sel  = 1'b0;
        halt    = 1'b0;
        busy    = (state_q != S_FETCH);
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_cls == C_ILLEGAL) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
                    retire  = 1'b1;
`endif
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_R: begin
                        r_type  = 1'b1;
                        state_d = S_WB;
                    end
                    C_I: begin
                        i_type  = 1'b1;
                        state_d = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_add = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BRANCH: begin
                        pc_we   = branch_taken;
                        pc_sel  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (cls_q == C_LOAD);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: halt = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            retire  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            pc_sel  = 1'b0;
            r_type  = 1'b0;
            i_type  = 1'b0;
            alu_add = 1'b0;
            reg_we  = 1'b0;
            wb_sel  = 1'b0;
            halt    = 1'b0;
            busy    = 1'b0;
        end
    end

    assign instr_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase model with random memory waits, plus a 4-bit counter instance.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    // Output vector bit weights: {mem_req,mem_we,ir_we,pc_we,pc_sel,r_type,i_type,alu_add,reg_we,wb_sel,busy,halt}
    localparam logic [11:0] REQ = 12'h800, MWE = 12'h400, IRW = 12'h200, PCW = 12'h100;
    localparam logic [11:0] PCS = 12'h080, RT  = 12'h040, IT  = 12'h020, AA  = 12'h010;
    localparam logic [11:0] RW  = 12'h008, WBS = 12'h004, BSY = 12'h002, HLT = 12'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;

    logic mem_req, mem_we, ir_we, pc_we, pc_sel, r_type, i_type, alu_add, reg_we, wb_sel, busy, halt;
    logic [31:0] instr_count;
    logic u_mem_req, u_mem_we, u_ir_we, u_pc_we, u_pc_sel, u_r_type, u_i_type, u_alu_add;
    logic u_reg_we, u_wb_sel, u_busy, u_halt;
    logic [3:0]  cnt4;
    logic [11:0] act;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .r_type(r_type), .i_type(i_type), .alu_add(alu_add), .reg_we(reg_we), .wb_sel(wb_sel),
        .busy(busy), .halt(halt), .instr_count(instr_count)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(u_mem_req), .mem_we(u_mem_we), .ir_we(u_ir_we), .pc_we(u_pc_we), .pc_sel(u_pc_sel),
        .r_type(u_r_type), .i_type(u_i_type), .alu_add(u_alu_add), .reg_we(u_reg_we), .wb_sel(u_wb_sel),
        .busy(u_busy), .halt(u_halt), .instr_count(cnt4)
    );

    assign act = {mem_req, mem_we, ir_we, pc_we, pc_sel, r_type, i_type, alu_add,
                  reg_we, wb_sel, busy, halt};

    typedef struct {
        logic        ready;
        logic [11:0] exp;
        logic        ret;
    } cyc_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned mcount = 0;

    // Hold reset for n cycles checking that everything reads zero, then release so the next cycle is FETCH.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = 1'($urandom);
            branch_taken = 1'($urandom);
            opcode = 7'($urandom);
            #1;
            total++;
            if (act !== 12'h000) begin
                bad++;
                $display("FAIL reset_outputs: got %b want %b", act, 12'h000);
            end
            total++;
            if (instr_count !== 32'd0 || cnt4 !== 4'd0) begin
                bad++;
                $display("FAIL reset_count: got %0d/%0d want 0/0", instr_count, cnt4);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        mcount = 0;
    endtask

    // Build the expected per-cycle phase list for one instruction, then drive and compare it.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input logic taken,
                            input int stop);
        q.delete();
        for (int i = 0; i < fw; i++) q.push_back('{1'b0, REQ, 1'b0});
        q.push_back('{1'b1, REQ | IRW | PCW, 1'b0});
        case (op)
            OP_R: begin
                q.push_back('{1'b0, BSY, 1'b0});
                q.push_back('{1'b0, BSY | RT, 1'b0});
                q.push_back('{1'b0, BSY | RW, 1'b1});
            end
            OP_I: begin
                q.push_back('{1'b0, BSY, 1'b0});
                q.push_back('{1'b0, BSY | IT, 1'b0});
                q.push_back('{1'b0, BSY | RW, 1'b1});
            end
            OP_LD: begin
                q.push_back('{1'b0, BSY, 1'b0});
                q.push_back('{1'b0, BSY | AA, 1'b0});
                for (int i = 0; i < mw; i++) q.push_back('{1'b0, BSY | REQ, 1'b0});
                q.push_back('{1'b1, BSY | REQ, 1'b0});
                q.push_back('{1'b0, BSY | RW | WBS, 1'b1});
            end
            OP_ST: begin
                q.push_back('{1'b0, BSY, 1'b0});
                q.push_back('{1'b0, BSY | AA, 1'b0});
                for (int i = 0; i < mw; i++) q.push_back('{1'b0, BSY | REQ | MWE, 1'b0});
                q.push_back('{1'b1, BSY | REQ | MWE, 1'b1});
            end
            OP_BR: begin
                q.push_back('{1'b0, BSY, 1'b0});
                q.push_back('{1'b0, BSY | PCS | (taken ? PCW : 12'h000), 1'b1});
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                q.push_back('{1'b0, BSY, 1'b0});
                for (int i = 0; i < 12; i++) q.push_back('{1'b0, BSY | HLT, 1'b0});
`else
                q.push_back('{1'b0, BSY, 1'b1});
`endif
            end
        endcase
        for (int k = 0; k < q.size() && (stop < 0 || k < stop); k++) begin
            @(negedge clk);
            mem_ready = (q[k].exp & REQ) != 12'h000 ? q[k].ready : 1'($urandom);
            opcode = (k <= fw) ? 7'($urandom) : op;
            branch_taken = (q[k].exp & PCS) != 12'h000 ? taken : 1'($urandom);
            #1;
            total++;
            if (act !== q[k].exp) begin
                bad++;
                $display("FAIL ctrl op=%b cyc=%0d: got %b want %b", op, k, act, q[k].exp);
            end
            total++;
            if (instr_count !== mcount) begin
                bad++;
                $display("FAIL count op=%b cyc=%0d: got %0d want %0d", op, k, instr_count, mcount);
            end
            total++;
            if (cnt4 !== 4'(mcount)) begin
                bad++;
                $display("FAIL count4 op=%b cyc=%0d: got %0d want %0d", op, k, cnt4, 4'(mcount));
            end
            if (q[k].ret) mcount++;
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (act !== REQ) begin
            bad++;
            $display("FAIL first_fetch: got %b want %b", act, REQ);
        end
    endtask

    task automatic test_add();
        do_reset(2);
        do_instr(OP_R, 0, 0, 1'b0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (instr_count !== 32'd1 || act !== REQ) begin
            bad++;
            $display("FAIL add_cycle4: got count=%0d ctrl=%b want count=1 ctrl=%b", instr_count, act, REQ);
        end
    endtask

    task automatic test_load_wait();
        do_reset(1);
        do_instr(OP_LD, 0, 2, 1'b0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (instr_count !== 32'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_cycle7: got count=%0d busy=%b want count=1 busy=0", instr_count, busy);
        end
    endtask

    task automatic test_store_branch();
        do_reset(1);
        do_instr(OP_ST, 1, 0, 1'b0, -1);
        do_instr(OP_BR, 0, 0, 1'b1, -1);
        do_instr(OP_BR, 2, 0, 1'b0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (instr_count !== 32'd3) begin
            bad++;
            $display("FAIL store_branch_count: got %0d want 3", instr_count);
        end
    endtask

    task automatic test_illegal();
        do_reset(1);
        do_instr(OP_ILL, 0, 0, 1'b0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
`ifdef MC_ILLEGAL_TRAP_EN
        if (halt !== 1'b1 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL trap_hold: got halt=%b count=%0d want halt=1 count=0", halt, instr_count);
        end
`else
        if (instr_count !== 32'd1 || act !== REQ) begin
            bad++;
            $display("FAIL illegal_nop: got count=%0d ctrl=%b want count=1 ctrl=%b", instr_count, act, REQ);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        do_instr(OP_I, 0, 0, 1'b0, -1);
        do_instr(OP_LD, 0, 4, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (act !== 12'h000 || instr_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_hold: got ctrl=%b count=%0d want ctrl=0 count=0", act, instr_count);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        mcount = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (act !== REQ || instr_count !== 32'd0 || cnt4 !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_fetch: got ctrl=%b count=%0d want ctrl=%b count=0", act, instr_count, REQ);
        end
        do_instr(OP_R, 0, 0, 1'b0, -1);
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int i = 0; i < 16; i++) do_instr(OP_I, 0, 0, 1'b0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (cnt4 !== 4'd0 || instr_count !== 32'd16) begin
            bad++;
            $display("FAIL wrap: got cnt4=%0d count=%0d want 0/16", cnt4, instr_count);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        int         n;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, 7'b0000000};
`ifdef MC_ILLEGAL_TRAP_EN
        n = 5;
`else
        n = 6;
`endif
        do_reset(1);
        for (int i = 0; i < 40; i++)
            do_instr(ops[$urandom_range(0, n - 1)], int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), 1'($urandom), -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store_branch();
        test_reset_mid();
        test_wrap();
        test_random();
        test_illegal();
        do_reset(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
